// File: rtl/dg0045_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dg0045_pkg
//  Description : Shared widths, phase constants and helpers for the DG0045
//                program-ROM responder.
//  Revision    : 1.0  initial release
// ============================================================================
package dg0045_pkg;

    localparam int DG_PC_W    = 10;
    localparam int DG_HALF_W  = 5;
    localparam int DG_PHASE_W = 3;

    localparam logic [7:0] DG_NOP = 8'h00;

    typedef logic [DG_PHASE_W-1:0] dg_phase_t;
    typedef logic [DG_PC_W-1:0]    dg_pc_t;
    typedef logic [DG_HALF_W-1:0]  dg_half_t;

    localparam dg_phase_t PH_CAP_LO = 3'd7;
    localparam dg_phase_t PH_CAP_HI = 3'd0;
    localparam dg_phase_t PH_READ   = 3'd1;

    // {PU[3:0],PL[5]} rides in the upper half, PL[4:0] in the lower half.
    function automatic dg_pc_t dg_join_pc(input dg_half_t hi, input dg_half_t lo);
        return {hi, lo};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dg0045_rom_array.sv
`default_nettype none
// ============================================================================
//  Module      : dg0045_rom_array
//  Description : ROM_DEPTH x 8 image store, one synchronous write port and one
//                registered read port; out-of-range accesses read NOP.
//  Revision    : 1.0  initial release
// ============================================================================
module dg0045_rom_array
    import dg0045_pkg::*;
#(
    parameter int ROM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [DG_PC_W-1:0] wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               rd_en,
    input  logic [DG_PC_W-1:0] rd_addr,
    output logic [7:0]         rd_data
);

    localparam int DEPTH_EFF = (ROM_DEPTH > (1 << DG_PC_W)) ? (1 << DG_PC_W) : ROM_DEPTH;
    localparam int AW        = (DEPTH_EFF > 1) ? $clog2(DEPTH_EFF) : 1;

    typedef logic [DG_PC_W:0] lim_t;
    localparam lim_t ADDR_LIMIT = lim_t'(DEPTH_EFF);

    logic [7:0]    mem_q [DEPTH_EFF];
    logic [7:0]    rd_data_d;
    logic [7:0]    rd_data_q;
    logic          wr_in_range;
    logic          rd_in_range;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_in_range = ({1'b0, wr_addr} < ADDR_LIMIT);
    assign rd_in_range = ({1'b0, rd_addr} < ADDR_LIMIT);
    assign wr_idx      = wr_addr[AW-1:0];
    assign rd_idx      = rd_addr[AW-1:0];

    // Out-of-range writes are accepted upstream and simply dropped here.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_in_range ? mem_q[rd_idx] : DG_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= DG_NOP;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/dg0045_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dg0045_rom_responder
//  Description : Far end of the DG0045 fetch interface: mirrors the core's
//                8-clock machine cycle, assembles the PC and returns the byte.
//  Revision    : 1.0  initial release
// ============================================================================
module dg0045_rom_responder
    import dg0045_pkg::*;
#(
    parameter int ROM_DEPTH    = 1024,
    parameter int PHASE_OFFSET = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DG_HALF_W-1:0] pc_hl,
    output logic                 pc_mux,
    output logic [7:0]           rom_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [DG_PC_W-1:0]   ld_addr,
    input  logic [7:0]           ld_data,
    output logic [DG_PC_W-1:0]   fetch_addr,
    output logic                 fetch_stb
);

    localparam dg_phase_t PHASE_RST = dg_phase_t'(PHASE_OFFSET);

    dg_phase_t phase_d,      phase_q;
    logic      pc_mux_d,     pc_mux_q;
    dg_half_t  lo_d,         lo_q;
    dg_half_t  hi_d,         hi_q;
    logic      lo_seen_d,    lo_seen_q;
    dg_pc_t    fetch_addr_d, fetch_addr_q;
    logic      fetch_stb_d,  fetch_stb_q;

    logic      rd_en;
    logic      wr_en;

    // A read is only issued once a low half has been captured since reset, so a
    // sequence cut short by reset never produces a half-formed address.
    always_comb begin
        phase_d      = phase_q + 3'd1;
        pc_mux_d     = (phase_d == PH_CAP_HI);
        lo_d         = lo_q;
        hi_d         = hi_q;
        lo_seen_d    = lo_seen_q;
        fetch_addr_d = fetch_addr_q;
        fetch_stb_d  = 1'b0;
        case (phase_q)
            PH_CAP_LO: begin
                lo_d      = pc_hl;
                lo_seen_d = 1'b1;
            end
            PH_CAP_HI: begin
                hi_d = pc_hl;
            end
            PH_READ: begin
                if (lo_seen_q) begin
                    fetch_addr_d = dg_join_pc(hi_q, lo_q);
                    fetch_stb_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PHASE_RST;
            pc_mux_q     <= 1'b0;
            lo_q         <= '0;
            hi_q         <= '0;
            lo_seen_q    <= 1'b0;
            fetch_addr_q <= '0;
            fetch_stb_q  <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            pc_mux_q     <= pc_mux_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            lo_seen_q    <= lo_seen_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_stb_q  <= fetch_stb_d;
        end
    end

    // The read slot owns the array in phase 1, so writes never collide with it.
    assign ld_ready = (phase_q != PH_READ);
    assign wr_en    = ld_valid && ld_ready;
    assign rd_en    = (phase_q == PH_READ) && lo_seen_q;

    dg0045_rom_array #(
        .ROM_DEPTH (ROM_DEPTH)
    ) u_rom_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_en   (rd_en),
        .rd_addr (dg_join_pc(hi_q, lo_q)),
        .rd_data (rom_data)
    );

    assign pc_mux     = pc_mux_q;
    assign fetch_addr = fetch_addr_q;
    assign fetch_stb  = fetch_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_dg0045_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dg0045_rom_responder
//  Description : Self-checking bench: core PC model plus ROM reference model,
//                two responders (full depth and 256-word depth) side by side.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dg0045_rom_responder;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] pc_hl;
    logic       ld_valid = 1'b0;
    logic [9:0] ld_addr  = '0;
    logic [7:0] ld_data  = '0;

    logic       pc_mux0, pc_mux1, ld_ready0, ld_ready1, fetch_stb0, fetch_stb1;
    logic [7:0] rom_data0, rom_data1;
    logic [9:0] fetch_addr0, fetch_addr1;

    always #5 clk = ~clk;

    dg0045_rom_responder #(.ROM_DEPTH(1024), .PHASE_OFFSET(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .pc_hl(pc_hl), .pc_mux(pc_mux0), .rom_data(rom_data0),
        .ld_valid(ld_valid), .ld_ready(ld_ready0), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_addr(fetch_addr0), .fetch_stb(fetch_stb0)
    );

    dg0045_rom_responder #(.ROM_DEPTH(256), .PHASE_OFFSET(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pc_hl(pc_hl), .pc_mux(pc_mux1), .rom_data(rom_data1),
        .ld_valid(ld_valid), .ld_ready(ld_ready1), .ld_addr(ld_addr), .ld_data(ld_data),
        .fetch_addr(fetch_addr1), .fetch_stb(fetch_stb1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: core PC timing, ROM image and the word each fetch returns.
    logic [7:0] mem   [1024];
    bit         known [1024] = '{default: 1'b0};
    int         ph;
    int         edges;
    bit         seen_lo;
    logic [9:0] core_pc;
    bit         inc_en   = 1'b0;
    int         jmp_req  = 0;
    int         jmp_done = 0;
    logic [9:0] jmp_tgt  = '0;
    logic [7:0] exp_rom0, exp_rom1;
    bit         exp_kn0, exp_kn1;
    logic [9:0] exp_addr;
    bit         exp_stb;
    bit         chk_en = 1'b1;

    assign pc_hl = pc_mux0 ? core_pc[9:5] : core_pc[4:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 0;
            edges    <= 0;
            seen_lo  <= 1'b0;
            core_pc  <= '0;
            exp_rom0 <= 8'h00;
            exp_rom1 <= 8'h00;
            exp_kn0  <= 1'b1;
            exp_kn1  <= 1'b1;
            exp_addr <= '0;
            exp_stb  <= 1'b0;
        end else begin
            ph      <= (ph + 1) % 8;
            if (edges < 1000000) edges <= edges + 1;
            exp_stb <= 1'b0;
            if (ph == 7) seen_lo <= 1'b1;
            if (ph == 1 && seen_lo) begin
                exp_addr <= core_pc;
                exp_rom0 <= mem[core_pc];
                exp_kn0  <= known[core_pc];
                exp_rom1 <= (core_pc < 10'd256) ? mem[core_pc] : 8'h00;
                exp_kn1  <= (core_pc >= 10'd256) || known[core_pc];
                exp_stb  <= 1'b1;
            end
            if (ld_valid && ph != 1) begin
                mem[ld_addr]   <= ld_data;
                known[ld_addr] <= 1'b1;
            end
            if (ph == 1 && inc_en) core_pc <= core_pc + 10'd1;
            if (ph == 5 && jmp_req != jmp_done) begin
                core_pc  <= jmp_tgt;
                jmp_done <= jmp_req;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("pc_mux0",   32'(pc_mux0),    32'(rst_n && ph == 0 && edges > 0));
            check_eq("pc_mux1",   32'(pc_mux1),    32'(rst_n && ph == 0 && edges > 0));
            check_eq("ld_ready0", 32'(ld_ready0),  32'(ph != 1));
            check_eq("ld_ready1", 32'(ld_ready1),  32'(ph != 1));
            check_eq("stb0",      32'(fetch_stb0), 32'(exp_stb));
            check_eq("stb1",      32'(fetch_stb1), 32'(exp_stb));
            check_eq("faddr0",    32'(fetch_addr0), 32'(exp_addr));
            check_eq("faddr1",    32'(fetch_addr1), 32'(exp_addr));
            if (exp_kn0) check_eq("rom0", 32'(rom_data0), 32'(exp_rom0));
            if (exp_kn1) check_eq("rom1", 32'(rom_data1), 32'(exp_rom1));
        end
    end

    task automatic wait_phase(input int p);
        bit hit = 1'b0;
        for (int i = 0; i < 16 && !hit; i++) begin
            @(negedge clk);
            if (ph == p) hit = 1'b1;
        end
        check_eq("phase_reach", 32'(hit), 32'd1);
    endtask

    task automatic ld_write(input logic [9:0] a, input logic [7:0] d, output int stalls);
        bit acc = 1'b0;
        stalls   = 0;
        ld_addr  = a;
        ld_data  = d;
        ld_valid = 1'b1;
        for (int i = 0; i < 4 && !acc; i++) begin
            if (ld_ready0) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        ld_valid = 1'b0;
        check_eq("ld_accept", 32'(acc), 32'd1);
    endtask

    task automatic jump_to(input logic [9:0] a);
        jmp_tgt = a;
        jmp_req++;
        wait_phase(6);
        wait_phase(2);
    endtask

    initial begin
        int st;
        logic [9:0] ra;

        // Reset held, then released; outputs must sit at reset values.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_pc_mux", 32'(pc_mux0),    32'd0);
        check_eq("rst_rom",    32'(rom_data0),  32'h00);
        check_eq("rst_stb",    32'(fetch_stb0), 32'd0);
        check_eq("rst_ready",  32'(ld_ready0),  32'd1);
        @(negedge clk);

        for (int a = 0; a < 1024; a++) ld_write(10'(a), 8'($urandom), st);

        // Directed load and fetch at PC 0.
        ld_write(10'h000, 8'hA1, st);
        ld_write(10'h001, 8'hB2, st);
        ld_write(10'h002, 8'hC3, st);
        ld_write(10'h003, 8'hD4, st);
        wait_phase(3);
        wait_phase(2);
        check_eq("t2_rom",  32'(rom_data0),  32'hA1);
        check_eq("t2_stb",  32'(fetch_stb0), 32'd1);
        wait_phase(1);
        check_eq("t2_hold", 32'(rom_data0),  32'hA1);
        check_eq("t2_stb0", 32'(fetch_stb0), 32'd0);

        // Split-half address assembly.
        ld_write(10'h3A5, 8'h3C, st);
        jump_to(10'h3A5);
        check_eq("t3_addr",  32'(fetch_addr0), 32'h3A5);
        check_eq("t3_rom",   32'(rom_data0),   32'h3C);
        check_eq("t3_rom1",  32'(rom_data1),   32'h00);

        // Increment at phase 2 entry, then jump at phase 6 entry.
        ld_write(10'h010, 8'h11, st);
        ld_write(10'h011, 8'h22, st);
        ld_write(10'h020, 8'h33, st);
        inc_en = 1'b1;
        jump_to(10'h010);
        check_eq("t4_first", 32'(rom_data0), 32'h11);
        wait_phase(5);
        check_eq("t4_held",  32'(rom_data0), 32'h11);
        wait_phase(2);
        check_eq("t4_inc",   32'(rom_data0), 32'h22);
        jump_to(10'h020);
        check_eq("t4_jmp",   32'(rom_data0), 32'h33);
        inc_en = 1'b0;

        // Write to the address currently on rom_data, requested in the read slot.
        ld_write(10'h040, 8'h77, st);
        jump_to(10'h040);
        check_eq("t5_before", 32'(rom_data0), 32'h77);
        wait_phase(1);
        check_eq("t5_busy",   32'(ld_ready0), 32'd0);
        ld_write(10'h040, 8'h5E, st);
        check_eq("t5_stall",  32'(st),        32'd1);
        check_eq("t5_kept",   32'(rom_data0), 32'h77);
        wait_phase(1);
        check_eq("t5_kept1",  32'(rom_data0), 32'h77);
        wait_phase(2);
        check_eq("t5_new",    32'(rom_data0), 32'h5E);

        // Out-of-range on the 256-word instance, then a mid-cycle reset.
        ld_write(10'h100, 8'hE7, st);
        jump_to(10'h100);
        check_eq("t6_rom1",  32'(rom_data1),   32'h00);
        check_eq("t6_rom0",  32'(rom_data0),   32'hE7);
        check_eq("t6_addr1", 32'(fetch_addr1), 32'h100);
        wait_phase(5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_rom0",  32'(rom_data0),   32'h00);
        check_eq("t6_rst_addr0", 32'(fetch_addr0), 32'h000);
        check_eq("t6_rst_mux0",  32'(pc_mux0),     32'd0);
        check_eq("t6_rst_stb1",  32'(fetch_stb1),  32'd0);
        check_eq("t6_rst_rom1",  32'(rom_data1),   32'h00);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_phase(2);
        check_eq("t6_nop",   32'(rom_data0),  32'h00);
        check_eq("t6_nostb", 32'(fetch_stb0), 32'd0);
        wait_phase(2);
        check_eq("t6_refetch", 32'(rom_data0), 32'hA1);

        // Random machine cycles: increments, jumps and loads in any phase.
        for (int n = 0; n < 200; n++) begin
            inc_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                jmp_tgt = 10'($urandom);
                jmp_req++;
            end
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                ra = ($urandom_range(0, 1) == 0) ? core_pc : 10'($urandom);
                ld_write(ra, 8'($urandom), st);
            end
            wait_phase(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
